// File: rtl/systolic_skew_feeder.sv
// Streams a stored DIM x DIM operand tile into the systolic west edge, lane i delayed i cycles.
// Latency: first lane data one en-cycle after start; backpressure: en=0 freezes all state and outputs.
module systolic_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     WrEn,
    input  logic [$clog2(DIM)-1:0]   wr_row,
    input  logic [DIM*BITS_AB-1:0]   wr_data,
    input  logic                     start,
    output logic [DIM*BITS_AB-1:0]   Aout,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(2*DIM);
    // Counter value once the final diagonal (t = 2*DIM-2) has been driven.
    localparam logic [CW-1:0] LAST = CW'(2*DIM-1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [DIM*BITS_AB-1:0]  mem [DIM];
    logic [DIM*BITS_AB-1:0]  lanes;
    logic [DIM*BITS_AB-1:0]  aout_nxt;
    logic                    valid_nxt, busy_nxt, done_nxt, wr_go;
    int                      d;

    always_comb begin
        lanes = '0;
        d     = 0;
        for (int i = 0; i < DIM; i++) begin
            d = int'(cnt) - i;
            if (d >= 0 && d < DIM)
                lanes[i*BITS_AB +: BITS_AB] = mem[i][d*BITS_AB +: BITS_AB];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        aout_nxt  = '0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        wr_go     = 1'b0;
        case (state)
            IDLE, DONE: begin
                // start beats a same-cycle write so the tile is never torn.
                if (start) begin
                    state_nxt = STREAM;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    wr_go     = WrEn && (int'(wr_row) < DIM);
                end
            end
            STREAM: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    aout_nxt  = lanes;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            Aout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int r = 0; r < DIM; r++)
                mem[r] <= '0;
        end else if (en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Aout  <= aout_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (wr_go)
                mem[wr_row] <= wr_data;
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Random and directed stimulus for systolic_skew_feeder (DIM=4), checked against a schedule-based tile model.
module tb_systolic_skew_feeder;

    localparam int B = 8;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            WrEn = 1'b0;
    logic [1:0]      wr_row = '0;
    logic [N*B-1:0]  wr_data = '0;
    logic            start = 1'b0;
    logic [N*B-1:0]  Aout;
    logic            valid, busy, done;

    systolic_skew_feeder #(.BITS_AB(B), .DIM(N)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .wr_row(wr_row),
        .wr_data(wr_data), .start(start), .Aout(Aout), .valid(valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*B-1:0] aout;
        logic           valid;
        logic           busy;
        logic           done;
    } exp_t;

    logic [B-1:0] tile [N][N];
    exp_t         sched[$];
    exp_t         cur;
    exp_t         idle_o;
    int           vectors = 0;
    int           errors  = 0;
    int           vcount, dcount;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*B-1:0] diag(input int t);
        logic [N*B-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N)
                v[i*B +: B] = tile[i][t-i];
        return v;
    endfunction

    // A start seen while nothing is scheduled queues the whole output
    // timeline of one tile: a busy-only cycle, 2N-1 diagonals, then done.
    task automatic model_edge();
        if (!en) return;
        if (sched.size() == 0) begin
            if (start) begin
                sched.push_back('{aout: '0, valid: 1'b0, busy: 1'b1, done: 1'b0});
                for (int t = 0; t < 2*N-1; t++)
                    sched.push_back('{aout: diag(t), valid: 1'b1, busy: 1'b1, done: 1'b0});
                sched.push_back('{aout: '0, valid: 1'b0, busy: 1'b0, done: 1'b1});
                cur = sched.pop_front();
            end else begin
                if (WrEn)
                    for (int j = 0; j < N; j++)
                        tile[wr_row][j] = wr_data[j*B +: B];
                cur = idle_o;
            end
        end else begin
            cur = sched.pop_front();
        end
    endtask

    task automatic check_outs();
        chk("aout",  64'(Aout),  64'(cur.aout));
        chk("valid", 64'(valid), 64'(cur.valid));
        chk("busy",  64'(busy),  64'(cur.busy));
        chk("done",  64'(done),  64'(cur.done));
    endtask

    task automatic step(input logic e, input logic s, input logic w,
                        input logic [1:0] r, input logic [N*B-1:0] dat);
        en = e; start = s; WrEn = w; wr_row = r; wr_data = dat;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        if (e && valid) vcount++;
        if (e && done)  dcount++;
    endtask

    task automatic clear_model();
        sched.delete();
        cur = idle_o;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                tile[i][j] = '0;
    endtask

    // Assert reset between edges and look at outputs before any clock.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        clear_model();
        #1 check_outs();
        #1 rst_n = 1'b1;
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);
    endtask

    logic [N*B-1:0] row;

    initial begin
        idle_o = '{aout: '0, valid: 1'b0, busy: 1'b0, done: 1'b0};
        clear_model();
        #3;
        check_outs();
        #4 rst_n = 1'b1;

        // Ramp tile, then stream with known diagonals.
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) row[j*B +: B] = B'(10*r + j);
            step(1'b1, 1'b0, 1'b1, 2'(r), row);
        end
        vcount = 0; dcount = 0;
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        for (int t = 0; t < 2*N-1; t++) begin
            step(1'b1, 1'b0, 1'b0, 2'd0, '0);
            if (t == 0) chk("t0_lanes", 64'(Aout), 64'h0);
            if (t == 3) chk("t3_lanes", 64'(Aout), 64'h1E150C03);
            if (t == 6) chk("t6_lanes", 64'(Aout), 64'h21000000);
        end
        step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        idle_steps(2);
        chk("valid_cnt", 64'(vcount), 64'd7);
        chk("done_cnt",  64'(dcount), 64'd1);

        // Signed extremes on lane 0.
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'hFE7F80FF);
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        for (int t = 0; t < 2*N-1; t++) begin
            step(1'b1, 1'b0, 1'b0, 2'd0, '0);
            if (t == 1) chk("neg_lane0_t1", 64'(Aout[7:0]), 64'h80);
            if (t == 3) chk("neg_lane0_t3", 64'(Aout[7:0]), 64'hFE);
        end
        idle_steps(2);

        // Stall for 3 cycles after t=2.
        vcount = 0;
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 2'd2, 32'hDEADBEEF);
        for (int t = 3; t < 2*N; t++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        chk("stall_valid_cnt", 64'(vcount), 64'd7);
        idle_steps(1);

        // start+WrEn same cycle drops the write; writes mid-stream ignored.
        step(1'b1, 1'b1, 1'b1, 2'd1, 32'h63636363);
        for (int t = 0; t < 2*N; t++) step(1'b1, 1'b0, 1'b1, 2'd1, 32'h63636363);
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        for (int t = 0; t < 2*N; t++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        idle_steps(1);

        // Reset mid-stream, then stream the cleared tile.
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        pulse_reset();
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        for (int t = 0; t < 2*N; t++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        idle_steps(1);

        // start held high: DONE goes straight back to STREAM.
        step(1'b1, 1'b0, 1'b1, 2'd3, 32'h81C0017F);
        for (int t = 0; t < 2*N+1; t++) step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        chk("b2b_done", 64'(done), 64'd1);
        step(1'b1, 1'b1, 1'b0, 2'd0, '0);
        chk("b2b_busy", 64'(busy), 64'd1);
        for (int t = 0; t < 2*N; t++) step(1'b1, 1'b0, 1'b0, 2'd0, '0);

        // Random traffic with occasional stalls and resets.
        for (int k = 0; k < 600; k++) begin
            step(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
                 2'($urandom), $urandom);
            if (($urandom % 150) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
